// File: rtl/ddr_sdram_responder.sv
// DDR SDRAM command-bus responder: tracks the JEDEC init sequence, enforces
// command spacing, serves bursts from a small array and latches the first protocol error.
module ddr_sdram_responder #(
  parameter int tRP      = 3,
  parameter int tMRD     = 2,
  parameter int tRFC     = 11,
  parameter int tRCD     = 3,
  parameter int COL_BITS = 6
) (
  input  logic        clk133_p,
  input  logic        rst,
  input  logic        sd_CKE,
  input  logic        sd_CS,
  input  logic        sd_RAS,
  input  logic        sd_CAS,
  input  logic        sd_WE,
  input  logic [1:0]  sd_BA,
  input  logic [12:0] sd_A,
  input  logic [15:0] sd_DQ_in,
  input  logic        sd_LDM,
  input  logic        sd_UDM,
  output logic [15:0] sd_DQ_out,
  output logic        sd_DQ_oe,
  output logic        sd_DQS_out,
  output logic [12:0] modeReg,
  output logic [12:0] extModeReg,
  output logic        initDone,
  output logic        errorFlag,
  output logic [2:0]  errorCode
);

  typedef enum logic [3:0] {
    S_WAIT_CKE, S_PRE0, S_EMR, S_MR0, S_PRE1, S_REF0, S_REF1, S_MR1, S_READY
  } init_state_t;

  localparam logic [2:0] CMD_LMR = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam int         AW      = COL_BITS + 2;

  init_state_t         state_q, state_d;
  logic [7:0]          busy_cnt;
  logic [3:0]          bank_open;
  logic [15:0]         mem [0:(1<<AW)-1];

  logic [3:0]          bst_left;
  logic [1:0]          bst_wait;
  logic                bst_wr;
  logic [1:0]          bst_bank;
  logic [COL_BITS-1:0] bst_col;
  logic [2:0]          bst_beat;
  logic [2:0]          bst_mask;

  logic [2:0]          cmd;
  logic                cmd_valid;
  logic                init_match;
  logic                mode_ok;
  logic                err_hit;
  logic [2:0]          err_val;
  logic                do_lmr, do_ref, do_pre, do_act, do_wr, do_rd;
  logic [3:0]          burst_len;
  logic [1:0]          cas_lat;
  logic                beat_now, wr_beat, rd_beat;
  logic [COL_BITS-1:0] beat_col;
  logic [AW-1:0]       beat_idx;

  assign cmd       = {sd_RAS, sd_CAS, sd_WE};
  assign cmd_valid = sd_CKE && !sd_CS && (cmd[2:1] != 2'b11);
  assign mode_ok   = (sd_A[2:0] inside {3'd1, 3'd2, 3'd3}) && (sd_A[6:4] inside {3'd2, 3'd3});
  assign initDone  = (state_q == S_READY);

  always_comb begin
    case (modeReg[2:0])
      3'd2:    burst_len = 4'd4;
      3'd3:    burst_len = 4'd8;
      default: burst_len = 4'd2;
    endcase
    cas_lat = (modeReg[6:4] == 3'd3) ? 2'd3 : 2'd2;
  end

  always_comb begin
    case (state_q)
      S_PRE0, S_PRE1: init_match = (cmd == CMD_PRE) && sd_A[10];
      S_EMR:          init_match = (cmd == CMD_LMR) && (sd_BA == 2'b01);
      S_MR0, S_MR1:   init_match = (cmd == CMD_LMR) && (sd_BA == 2'b00);
      S_REF0, S_REF1: init_match = (cmd == CMD_REF);
      default:        init_match = 1'b0;
    endcase
  end

  // Command acceptance; checks are ordered so the lowest error code wins.
  always_comb begin
    state_d = state_q;
    err_hit = 1'b0;
    err_val = 3'd0;
    do_lmr  = 1'b0;
    do_ref  = 1'b0;
    do_pre  = 1'b0;
    do_act  = 1'b0;
    do_wr   = 1'b0;
    do_rd   = 1'b0;
    case (state_q)
      S_WAIT_CKE: if (sd_CKE) state_d = S_PRE0;
      S_READY: if (cmd_valid) begin
        if (busy_cnt != 8'd0) begin
          err_hit = 1'b1; err_val = 3'd2;
        end else begin
          case (cmd)
            CMD_LMR: do_lmr = 1'b1;
            CMD_REF: if (|bank_open) begin err_hit = 1'b1; err_val = 3'd6; end
                     else do_ref = 1'b1;
            CMD_PRE: do_pre = 1'b1;
            CMD_ACT: if (bank_open[sd_BA]) begin err_hit = 1'b1; err_val = 3'd4; end
                     else do_act = 1'b1;
            default: begin
              if (!bank_open[sd_BA]) begin
                err_hit = 1'b1; err_val = 3'd3;
              end else if (bst_left != 4'd0) begin
                err_hit = 1'b1; err_val = 3'd7;
              end else if (cmd == CMD_WR) begin
                do_wr = 1'b1;
              end else begin
                do_rd = 1'b1;
              end
            end
          endcase
        end
      end
      default: if (cmd_valid) begin
        if (!init_match) begin
          err_hit = 1'b1; err_val = 3'd1;
        end else if (busy_cnt != 8'd0) begin
          err_hit = 1'b1; err_val = 3'd2;
        end else begin
          do_lmr = (cmd == CMD_LMR);
          do_ref = (cmd == CMD_REF);
          do_pre = (cmd == CMD_PRE);
          case (state_q)
            S_PRE0:  state_d = S_EMR;
            S_EMR:   state_d = S_MR0;
            S_MR0:   state_d = S_PRE1;
            S_PRE1:  state_d = S_REF0;
            S_REF0:  state_d = S_REF1;
            S_REF1:  state_d = S_MR1;
            S_MR1:   state_d = S_READY;
            default: state_d = state_q;
          endcase
        end
      end
    endcase
    if (do_lmr && (sd_BA == 2'b00) && !mode_ok) begin
      err_hit = 1'b1; err_val = 3'd5;
    end
  end

  always_ff @(posedge clk133_p) begin
    if (rst) state_q <= S_WAIT_CKE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk133_p) begin
    if (rst) begin
      busy_cnt   <= 8'd0;
      bank_open  <= 4'b0;
      modeReg    <= 13'd0;
      extModeReg <= 13'd0;
      errorFlag  <= 1'b0;
      errorCode  <= 3'd0;
    end else begin
      if (do_pre)                busy_cnt <= 8'(tRP - 1);
      else if (do_lmr)           busy_cnt <= 8'(tMRD - 1);
      else if (do_ref)           busy_cnt <= 8'(tRFC - 1);
      else if (do_act)           busy_cnt <= 8'(tRCD - 1);
      else if (busy_cnt != 8'd0) busy_cnt <= busy_cnt - 8'd1;
      if (do_pre) begin
        if (sd_A[10]) bank_open <= 4'b0;
        else          bank_open[sd_BA] <= 1'b0;
      end
      if (do_act) bank_open[sd_BA] <= 1'b1;
      if (do_lmr) begin
        if (sd_BA == 2'b00)      modeReg    <= sd_A;
        else if (sd_BA == 2'b01) extModeReg <= sd_A;
      end
      if (err_hit && !errorFlag) begin
        errorFlag <= 1'b1;
        errorCode <= err_val;
      end
    end
  end

  // A read waits CL-1 cycles before its first beat; a write beats right away.
  always_ff @(posedge clk133_p) begin
    if (rst) begin
      bst_left <= 4'd0;
      bst_wait <= 2'd0;
      bst_wr   <= 1'b0;
      bst_bank <= 2'd0;
      bst_col  <= '0;
      bst_beat <= 3'd0;
      bst_mask <= 3'd0;
    end else if (do_wr || do_rd) begin
      bst_left <= burst_len;
      bst_wait <= do_rd ? cas_lat - 2'd1 : 2'd0;
      bst_wr   <= do_wr;
      bst_bank <= sd_BA;
      bst_col  <= sd_A[COL_BITS-1:0];
      bst_beat <= 3'd0;
      bst_mask <= burst_len[2:0] - 3'd1;
    end else if (bst_left != 4'd0) begin
      if (bst_wait != 2'd0) begin
        bst_wait <= bst_wait - 2'd1;
      end else begin
        bst_beat <= bst_beat + 3'd1;
        bst_left <= bst_left - 4'd1;
      end
    end
  end

  assign beat_now = (bst_left != 4'd0) && (bst_wait == 2'd0);
  assign wr_beat  = beat_now && bst_wr && !rst;
  assign rd_beat  = beat_now && !bst_wr;

  // Low log2(BL) column bits count modulo BL so the burst wraps in its aligned block.
  always_comb begin
    beat_col      = bst_col;
    beat_col[2:0] = (bst_col[2:0] & ~bst_mask) | ((bst_col[2:0] + bst_beat) & bst_mask);
  end
  assign beat_idx = {bst_bank, beat_col};

  always_ff @(posedge clk133_p) begin
    if (wr_beat) begin
      if (!sd_LDM) mem[beat_idx][7:0]  <= sd_DQ_in[7:0];
      if (!sd_UDM) mem[beat_idx][15:8] <= sd_DQ_in[15:8];
    end
  end

  always_ff @(posedge clk133_p) begin
    if (rst) begin
      sd_DQ_oe   <= 1'b0;
      sd_DQ_out  <= 16'd0;
      sd_DQS_out <= 1'b0;
    end else begin
      sd_DQ_oe   <= rd_beat;
      sd_DQ_out  <= rd_beat ? mem[beat_idx] : 16'd0;
      sd_DQS_out <= rd_beat ? ~sd_DQS_out : 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr_sdram_responder.sv
// Bench for ddr_sdram_responder: directed init/error scenarios plus random
// write/read bursts checked against a column-wrap memory model.
module tb_ddr_sdram_responder;

  localparam int T_RP = 3, T_MRD = 2, T_RFC = 11, T_RCD = 3, COLS = 64;
  localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011, C_WR = 3'b100, C_RD = 3'b101, C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        sd_CKE, sd_CS, sd_RAS, sd_CAS, sd_WE;
  logic [1:0]  sd_BA;
  logic [12:0] sd_A;
  logic [15:0] sd_DQ_in;
  logic        sd_LDM, sd_UDM;
  logic [15:0] sd_DQ_out;
  logic        sd_DQ_oe, sd_DQS_out;
  logic [12:0] modeReg, extModeReg;
  logic        initDone, errorFlag;
  logic [2:0]  errorCode;

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_mem [0:255];
  bit          ok_lo [0:255];
  bit          ok_hi [0:255];
  int          bl = 2;
  int          cl = 2;

  logic [15:0] wdata [8];
  logic        wldm [8];
  logic        wudm [8];
  logic        obs_oe [$];
  logic [15:0] obs_dq [$];
  logic        obs_dqs [$];
  logic [15:0] exp_q [$];
  bit          exp_ok [$];

  always #5 clk = ~clk;

  ddr_sdram_responder dut (
    .clk133_p(clk), .rst(rst), .sd_CKE(sd_CKE), .sd_CS(sd_CS),
    .sd_RAS(sd_RAS), .sd_CAS(sd_CAS), .sd_WE(sd_WE), .sd_BA(sd_BA), .sd_A(sd_A),
    .sd_DQ_in(sd_DQ_in), .sd_LDM(sd_LDM), .sd_UDM(sd_UDM),
    .sd_DQ_out(sd_DQ_out), .sd_DQ_oe(sd_DQ_oe), .sd_DQS_out(sd_DQS_out),
    .modeReg(modeReg), .extModeReg(extModeReg), .initDone(initDone),
    .errorFlag(errorFlag), .errorCode(errorCode)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // ---------------- model ----------------
  function automatic int mode_bl(input logic [12:0] mr);
    if (mr[2:0] == 3'd2) return 4;
    if (mr[2:0] == 3'd3) return 8;
    return 2;
  endfunction

  function automatic int mode_cl(input logic [12:0] mr);
    return (mr[6:4] == 3'd3) ? 3 : 2;
  endfunction

  function automatic int burst_addr(input int ba, input int col, input int k, input int blen);
    int base;
    base = col - (col % blen);
    return ba * COLS + base + ((col % blen) + k) % blen;
  endfunction

  function automatic void load_expect(input int ba, input int col);
    exp_q.delete();
    exp_ok.delete();
    for (int k = 0; k < bl; k++) begin
      int idx;
      idx = burst_addr(ba, col, k, bl);
      exp_q.push_back(ref_mem[idx]);
      exp_ok.push_back(ok_lo[idx] && ok_hi[idx]);
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a);
    sd_CKE = 1'b1;
    sd_CS  = 1'b0;
    {sd_RAS, sd_CAS, sd_WE} = c;
    sd_BA  = ba;
    sd_A   = a;
    tick();
    {sd_RAS, sd_CAS, sd_WE} = C_NOP;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sd_CKE = 1'b0;
    sd_CS = 1'b1;
    {sd_RAS, sd_CAS, sd_WE} = C_NOP;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ok_lo[i] = 1'b0;
      ok_hi[i] = 1'b0;
    end
    bl = 2;
    cl = 2;
  endtask

  task automatic init_seq(input logic [12:0] mr);
    issue(C_PRE, 2'd0, 13'h400); nop(T_RP - 1);
    issue(C_LMR, 2'd1, 13'h000); nop(T_MRD - 1);
    issue(C_LMR, 2'd0, mr);      nop(T_MRD - 1);
    issue(C_PRE, 2'd0, 13'h400); nop(T_RP - 1);
    issue(C_REF, 2'd0, 13'h000); nop(T_RFC - 1);
    issue(C_REF, 2'd0, 13'h000); nop(T_RFC - 1);
    issue(C_LMR, 2'd0, mr);      nop(T_MRD - 1);
    bl = mode_bl(mr);
    cl = mode_cl(mr);
  endtask

  task automatic do_init(input logic [12:0] mr);
    sd_CKE = 1'b1;
    tick();
    init_seq(mr);
  endtask

  task automatic do_write(input int ba, input int col);
    issue(C_WR, 2'(ba), 13'(col));
    for (int k = 0; k < bl; k++) begin
      int idx;
      idx = burst_addr(ba, col, k, bl);
      sd_DQ_in = wdata[k];
      sd_LDM = wldm[k];
      sd_UDM = wudm[k];
      tick();
      if (!wldm[k]) begin ref_mem[idx][7:0]  = wdata[k][7:0];  ok_lo[idx] = 1'b1; end
      if (!wudm[k]) begin ref_mem[idx][15:8] = wdata[k][15:8]; ok_hi[idx] = 1'b1; end
    end
    sd_DQ_in = 16'($urandom);
    sd_LDM = 1'b0;
    sd_UDM = 1'b0;
  endtask

  task automatic do_read(input int ba, input int col);
    obs_oe.delete();
    obs_dq.delete();
    obs_dqs.delete();
    issue(C_RD, 2'(ba), 13'(col));
    for (int k = 1; k <= cl + bl; k++) begin
      tick();
      obs_oe.push_back(sd_DQ_oe);
      obs_dq.push_back(sd_DQ_out);
      obs_dqs.push_back(sd_DQS_out);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({sd_DQ_oe, sd_DQS_out, sd_DQ_out, modeReg, extModeReg, initDone, errorFlag, errorCode} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: oe=%b dqs=%b dq=%h mr=%h emr=%h init=%b flag=%b code=%0d, all required 0",
               sd_DQ_oe, sd_DQS_out, sd_DQ_out, modeReg, extModeReg, initDone, errorFlag, errorCode);
    end
    nop(3);
    checks++;
    if (initDone !== 1'b0) begin
      errors++; $display("FAIL reset_hold_init: got %b required 0", initDone);
    end
  endtask

  task automatic test_init();
    do_init(13'h021);
    checks++;
    if (initDone !== 1'b1) begin errors++; $display("FAIL init_done: got %b required 1", initDone); end
    checks++;
    if (modeReg !== 13'h021) begin errors++; $display("FAIL init_mr: got %h required 021", modeReg); end
    checks++;
    if (extModeReg !== 13'h000) begin errors++; $display("FAIL init_emr: got %h required 000", extModeReg); end
    checks++;
    if ({errorFlag, errorCode} !== 4'b0) begin
      errors++; $display("FAIL init_err: flag=%b code=%0d required 0/0", errorFlag, errorCode);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] e_dq [4];
    bit e_oe [4];
    bit e_dqs [4];
    e_oe = '{0, 1, 1, 0};
    e_dqs = '{0, 1, 0, 0};
    e_dq = '{16'h0, 16'h3210, 16'h7654, 16'h0};
    issue(C_ACT, 2'd0, 13'd5);
    nop(T_RCD - 1);
    wdata[0] = 16'h3210; wdata[1] = 16'h7654;
    wldm[0] = 1'b0; wldm[1] = 1'b0; wudm[0] = 1'b0; wudm[1] = 1'b0;
    do_write(0, 0);
    do_read(0, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_oe[k] !== e_oe[k]) begin
        errors++; $display("FAIL wr_rd_oe cyc%0d: got %b required %b", k + 1, obs_oe[k], e_oe[k]);
      end
      checks++;
      if (obs_dqs[k] !== e_dqs[k]) begin
        errors++; $display("FAIL wr_rd_dqs cyc%0d: got %b required %b", k + 1, obs_dqs[k], e_dqs[k]);
      end
      if (e_oe[k]) begin
        checks++;
        if (obs_dq[k] !== e_dq[k]) begin
          errors++; $display("FAIL wr_rd_data cyc%0d: got %h required %h", k + 1, obs_dq[k], e_dq[k]);
        end
      end
    end
  endtask

  task automatic test_byte_mask();
    wdata[0] = 16'hFFFF; wldm[0] = 1'b0; wudm[0] = 1'b1;
    wdata[1] = 16'hFFFF; wldm[1] = 1'b1; wudm[1] = 1'b1;
    do_write(0, 1);
    do_read(0, 1);
    checks++;
    if (obs_oe[1] !== 1'b1 || obs_dq[1] !== 16'h76FF) begin
      errors++; $display("FAIL mask_word0: oe=%b data=%h required 1/76ff", obs_oe[1], obs_dq[1]);
    end
    checks++;
    if (obs_oe[2] !== 1'b1 || obs_dq[2] !== 16'h3210) begin
      errors++; $display("FAIL mask_word1: oe=%b data=%h required 1/3210", obs_oe[2], obs_dq[2]);
    end
  endtask

  task automatic test_random();
    logic [12:0] modes [3];
    modes = '{13'h021, 13'h032, 13'h023};
    for (int b = 1; b < 4; b++) begin
      issue(C_ACT, 2'(b), 13'($urandom));
      nop(T_RCD - 1);
    end
    for (int m = 0; m < 3; m++) begin
      issue(C_LMR, 2'd0, modes[m]);
      nop(T_MRD - 1);
      bl = mode_bl(modes[m]);
      cl = mode_cl(modes[m]);
      for (int it = 0; it < 6; it++) begin
        int ba, col, rcol;
        ba = $urandom_range(0, 3);
        col = $urandom_range(0, COLS - 1);
        for (int k = 0; k < 8; k++) begin
          wdata[k] = 16'($urandom);
          wldm[k] = ($urandom_range(0, 3) == 0);
          wudm[k] = ($urandom_range(0, 3) == 0);
        end
        do_write(ba, col);
        rcol = ($urandom_range(0, 1) == 0) ? col : $urandom_range(0, COLS - 1);
        load_expect(ba, rcol);
        do_read(ba, rcol);
        for (int k = 1; k <= cl + bl; k++) begin
          bit act;
          act = (k >= cl) && (k < cl + bl);
          checks++;
          if (obs_oe[k-1] !== act) begin
            errors++; $display("FAIL rand_oe bl%0d cyc%0d: got %b required %b", bl, k, obs_oe[k-1], act);
          end
          checks++;
          if (obs_dqs[k-1] !== (act && ((k - cl) % 2 == 0))) begin
            errors++; $display("FAIL rand_dqs bl%0d cyc%0d: got %b required %b", bl, k, obs_dqs[k-1],
                               act && ((k - cl) % 2 == 0));
          end
          if (act && exp_ok[k-cl]) begin
            checks++;
            if (obs_dq[k-1] !== exp_q[k-cl]) begin
              errors++; $display("FAIL rand_data b%0d c%0d beat%0d: got %h required %h",
                                 ba, rcol, k - cl, obs_dq[k-1], exp_q[k-cl]);
            end
          end
        end
      end
    end
    checks++;
    if (errorFlag !== 1'b0) begin
      errors++; $display("FAIL rand_no_error: flag=%b code=%0d required 0", errorFlag, errorCode);
    end
  endtask

  task automatic test_busy_error();
    int oe_seen;
    issue(C_PRE, 2'd3, 13'h000);
    issue(C_ACT, 2'd3, 13'd7);
    nop(T_RP);
    checks++;
    if (errorFlag !== 1'b1 || errorCode !== 3'd2) begin
      errors++; $display("FAIL busy_code: flag=%b code=%0d required 1/2", errorFlag, errorCode);
    end
    do_read(3, 0);
    oe_seen = 0;
    foreach (obs_oe[k]) if (obs_oe[k] !== 1'b0) oe_seen++;
    checks++;
    if (oe_seen != 0) begin errors++; $display("FAIL busy_bank_closed: oe cycles=%0d required 0", oe_seen); end
    checks++;
    if (errorCode !== 3'd2) begin errors++; $display("FAIL busy_code_kept: got %0d required 2", errorCode); end
  endtask

  task automatic test_init_error();
    do_reset();
    sd_CKE = 1'b1;
    tick();
    issue(C_ACT, 2'd0, 13'd0);
    checks++;
    if (errorCode !== 3'd1 || initDone !== 1'b0) begin
      errors++; $display("FAIL init_err_code: code=%0d init=%b required 1/0", errorCode, initDone);
    end
    init_seq(13'h021);
    checks++;
    if (initDone !== 1'b1 || errorCode !== 3'd1) begin
      errors++; $display("FAIL init_err_recover: init=%b code=%0d required 1/1", initDone, errorCode);
    end
  endtask

  task automatic test_closed_bank_read();
    int oe_seen;
    do_reset();
    do_init(13'h021);
    do_read(2, 5);
    oe_seen = 0;
    foreach (obs_oe[k]) if (obs_oe[k] !== 1'b0) oe_seen++;
    checks++;
    if (oe_seen != 0) begin errors++; $display("FAIL closed_oe: oe cycles=%0d required 0", oe_seen); end
    checks++;
    if (errorFlag !== 1'b1 || errorCode !== 3'd3) begin
      errors++; $display("FAIL closed_code: flag=%b code=%0d required 1/3", errorFlag, errorCode);
    end
  endtask

  task automatic test_back_to_back();
    int oe_seen;
    do_reset();
    do_init(13'h021);
    issue(C_ACT, 2'd0, 13'd1);
    nop(T_RCD - 1);
    issue(C_WR, 2'd0, 13'd0);
    sd_DQ_in = 16'hAAAA;
    issue(C_RD, 2'd0, 13'd0);
    sd_DQ_in = 16'h5555;
    oe_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sd_DQ_oe !== 1'b0) oe_seen++;
    end
    checks++;
    if (oe_seen != 0) begin errors++; $display("FAIL b2b_oe: oe cycles=%0d required 0", oe_seen); end
    checks++;
    if (errorCode !== 3'd7) begin errors++; $display("FAIL b2b_code: got %0d required 7", errorCode); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    do_init(13'h022);
    issue(C_ACT, 2'd1, 13'd2);
    nop(T_RCD - 1);
    for (int k = 0; k < 4; k++) begin
      wdata[k] = 16'($urandom); wldm[k] = 1'b0; wudm[k] = 1'b0;
    end
    do_write(1, 4);
    load_expect(1, 6);
    issue(C_RD, 2'd1, 13'd6);
    tick();
    checks++;
    if (sd_DQ_oe !== 1'b0) begin errors++; $display("FAIL rmb_early_oe: got %b required 0", sd_DQ_oe); end
    tick();
    checks++;
    if (sd_DQ_oe !== 1'b1 || sd_DQ_out !== exp_q[0]) begin
      errors++; $display("FAIL rmb_word0: oe=%b data=%h required 1/%h", sd_DQ_oe, sd_DQ_out, exp_q[0]);
    end
    tick();
    checks++;
    if (sd_DQ_oe !== 1'b1 || sd_DQ_out !== exp_q[1]) begin
      errors++; $display("FAIL rmb_word1: oe=%b data=%h required 1/%h", sd_DQ_oe, sd_DQ_out, exp_q[1]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({sd_DQ_oe, sd_DQS_out, initDone, modeReg} !== '0) begin
      errors++; $display("FAIL rmb_after_rst: oe=%b dqs=%b init=%b mr=%h required all 0",
                         sd_DQ_oe, sd_DQS_out, initDone, modeReg);
    end
    tick();
    checks++;
    if (sd_DQ_oe !== 1'b0) begin errors++; $display("FAIL rmb_stays_idle: oe=%b required 0", sd_DQ_oe); end
  endtask

  initial begin
    rst = 1'b1;
    sd_CKE = 1'b0;
    sd_CS = 1'b1;
    {sd_RAS, sd_CAS, sd_WE} = C_NOP;
    sd_BA = 2'd0;
    sd_A = 13'd0;
    sd_DQ_in = 16'd0;
    sd_LDM = 1'b0;
    sd_UDM = 1'b0;
    test_reset();
    test_init();
    test_write_read();
    test_byte_mask();
    test_random();
    test_busy_error();
    test_init_error();
    test_closed_bank_read();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
